fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of the terminal FIFO between NREQ independent producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time, holds the grant for a bounded burst, and forwards that producer's data to the FIFO write interface (wr_en, terminal_valid, wr_data, terminal_ready).
- It sits directly upstream of the terminal FIFO and is its only writer.

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the terminal FIFO write-side arbiter.
// FSM state encoding and the default data width tied to the FIFO width.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int DEF_WIDTH  = FIFO_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority selector: first set request at or after rr_ptr, with wrap.
// Kept standalone so a read-side scheduler can reuse it.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_req,
  output logic [IDX_W-1:0] sel_idx
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    any_req = |req;
    sel_idx = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) sel_idx = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the terminal FIFO write port among NREQ valid/ready producers.
// Grants are held for at most MAX_BURST accepted beats or until the producer withdraws.
//
// state    | meaning
// ST_IDLE  | no grant; pick next requester from rr_ptr
// ST_GRANT | gnt_idx owns the FIFO write port
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IDX_W     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    wr_en,
  output logic                    terminal_valid,
  output logic [WIDTH-1:0]        wr_data,
  input  logic                    terminal_ready,
  input  logic                    fifo_full,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [3:0]       beat_cnt;

  logic             any_req;
  logic [IDX_W-1:0] sel_idx;
  logic             cur_valid;
  logic             accept;
  logic             last_beat;
  logic [IDX_W-1:0] next_ptr;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .sel_idx (sel_idx)
  );

  assign cur_valid = req_valid[gnt_idx];
  assign accept    = (state == ST_GRANT) && cur_valid && terminal_ready && !fifo_full;
  assign last_beat = (beat_cnt == 4'(MAX_BURST - 1));
  // Pointer wraps at NREQ, which need not be a power of two.
  assign next_ptr  = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_GRANT;
            gnt_idx  <= sel_idx;
            beat_cnt <= '0;
            gnt      <= ONE << sel_idx;
            busy     <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!cur_valid || (accept && last_beat)) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
            gnt    <= '0;
            busy   <= 1'b0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en          = (state == ST_GRANT) && cur_valid;
  assign terminal_valid = wr_en;
  assign req_ready      = ((state == ST_GRANT) && terminal_ready && !fifo_full) ?
                          (ONE << gnt_idx) : '0;

  always_comb begin
    wr_data = '0;
    if (state == ST_GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (int'(gnt_idx) == i) wr_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int IDX_W     = 2;
  localparam int MAX_BURST = 4;
  localparam int NCYC      = 3000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_en;
  logic                  terminal_valid;
  logic [WIDTH-1:0]      wr_data;
  logic                  terminal_ready;
  logic                  fifo_full;
  logic [NREQ-1:0]       gnt;
  logic                  busy;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  bit m_granted;
  int m_owner;
  int m_ptr;
  int m_beats;
  int grant_log[$];
  int beats_log[$];

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wr_en          (wr_en),
    .terminal_valid (terminal_valid),
    .wr_data        (wr_data),
    .terminal_ready (terminal_ready),
    .fifo_full      (fifo_full),
    .gnt            (gnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slice(input int i);
    return req_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_granted = 1'b0;
    m_owner   = 0;
    m_ptr     = 0;
    m_beats   = 0;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0]  e_gnt;
    logic [NREQ-1:0]  e_rdy;
    logic             e_wr;
    logic [WIDTH-1:0] e_data;
    e_gnt  = '0;
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    if (m_granted) begin
      e_gnt[m_owner] = 1'b1;
      e_wr           = req_valid[m_owner];
      e_data         = slice(m_owner);
      if (terminal_ready && !fifo_full) e_rdy[m_owner] = 1'b1;
    end
    check("gnt",            32'(gnt),            32'(e_gnt));
    check("busy",           32'(busy),           32'(m_granted));
    check("req_ready",      32'(req_ready),      32'(e_rdy));
    check("wr_en",          32'(wr_en),          32'(e_wr));
    check("terminal_valid", 32'(terminal_valid), 32'(e_wr));
    check("wr_data",        32'(wr_data),        32'(e_data));
  endtask

  // Advance the model by one clock edge using the inputs presently applied.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!m_granted) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (req_valid[j]) begin
          m_granted = 1'b1;
          m_owner   = j;
          m_beats   = 0;
          grant_log.push_back(j);
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      beats_log.push_back(m_beats);
      m_granted = 1'b0;
      m_ptr     = (m_owner + 1) % NREQ;
    end else if (terminal_ready && !fifo_full) begin
      m_beats++;
      if (m_beats == MAX_BURST) begin
        beats_log.push_back(m_beats);
        m_granted = 1'b0;
        m_ptr     = (m_owner + 1) % NREQ;
      end
    end
  endtask

  initial begin
    int phase;
    int n_grants_phase0;
    rst            = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    terminal_ready = 1'b1;
    fifo_full      = 1'b0;
    model_reset();

    // reset with active requests must keep everything quiet
    @(negedge clk);
    req_valid = '1;
    req_data  = {$urandom, $urandom};
    @(negedge clk);
    #1;
    check("rst_gnt",       32'(gnt),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en",     32'(wr_en),     32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);

    n_grants_phase0 = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      phase = (cyc < 200) ? 0 : (cyc < 2000) ? 1 : 2;
      req_data = {$urandom, $urandom};
      if (phase == 0) begin
        rst            = (cyc == 0);
        req_valid      = '1;
        terminal_ready = 1'b1;
        fifo_full      = 1'b0;
      end else begin
        rst = ($urandom_range(0, 63) == 0);
        for (int i = 0; i < NREQ; i++)
          if ($urandom_range(0, 7) == 0) req_valid[i] = ~req_valid[i];
        terminal_ready = ($urandom_range(0, 7) != 0);
        fifo_full      = (phase == 2) ? ($urandom_range(0, 1) == 1)
                                      : ($urandom_range(0, 5) == 0);
      end
      #1;
      check_outputs();
      model_step();
      if (cyc == 199) n_grants_phase0 = grant_log.size();
    end

    // with everyone continuously valid and no back-pressure, grants rotate with full bursts
    for (int g = 0; g + 1 < n_grants_phase0; g++) begin
      check("rotation", 32'(grant_log[g + 1]), 32'((grant_log[g] + 1) % NREQ));
      check("burst_len", 32'(beats_log[g]), 32'(MAX_BURST));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
